dual_rail_rx: RTL and testbench
===============================

Name: dual_rail_rx

Overview:
- Clocked receiver that sits directly downstream of the dual-rail arithmetic stages, such as full_adder_tgl's {c_out,s} bundle.
- Synchronises the rail bundle into the clk domain and detects token completion for two-phase ("TP") or four-phase ("FP") encoding.
- Decodes each completed token to binary and presents it on a valid/ready interface to synchronous logic.
- Flags illegal codes and tokens lost to backpressure.

Parameters:
- ENC, "TP", encoding: "TP" = two-phase toggle, "FP" = four-phase return-to-zero.
- WIDTH, 2, number of dual-rail bits in the bundle.
- SYNC_STAGES, 2, flop stages per rail in the input synchroniser (legal range 2..4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in  in  [WIDTH-1:0][1:0]  dual-rail bundle; in[i][1] is the true rail, in[i][0] is the false rail.
- data_out  out  WIDTH  decoded token; bit i = 1 when the true rail carried the token.
- valid_out  out  1  data_out holds an unconsumed token.
- ready_in  in  1  consumer accepts data_out on a clk edge where valid_out && ready_in.
- err  out  1  sticky illegal-code flag.
- ovf  out  1  sticky overflow flag: a token completed while the output was still held.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - Synchroniser flops, s_q, ref and data_out clear to 0.
  - valid_out, err and ovf clear to 0.
  - FSM enters IDLE.
  - A reset mid-token discards any partial or held token. Reset does not by itself produce a token.
- Synchroniser:
  - Each rail passes through SYNC_STAGES flops, giving s.
  - s_q is s delayed by one cycle.
  - "stable" means s == s_q.
- TP completion:
  - ref holds the last accepted rail vector (reset 0).
  - Token is complete when, for every bit i, exactly one of s[i][1], s[i][0] differs from ref[i].
  - Decode: data_out[i] = s[i][1] ^ ref[i][1].
  - On acceptance, ref <= s.
- FP completion:
  - Token is complete when every pair is 01 or 10.
  - Spacer means every pair is 00.
  - Decode: data_out[i] = s[i][1].
- Illegal codes, which set err (sticky until rst):
  - TP: any pair with both rails differing from ref while stable.
  - FP: any pair equal to 11 while stable.
  - An illegal code is never accepted as a token.
- FSM:
  - IDLE: if complete && stable, latch data_out, set valid_out=1 on the next edge, and go to HOLD. Otherwise stay. Partial codes are ignored.
  - HOLD:
    - valid_out=1 and data_out frozen.
    - On valid_out && ready_in: valid_out=0 next edge; go to IDLE for TP, SPACER for FP.
    - If a further complete, stable, distinct token appears while in HOLD (TP only, since FP needs a spacer first): set ovf and drop the new token; ref still advances.
  - SPACER (FP only): wait for spacer && stable, then go to IDLE.
- Latency: once all rails are stable before a clk edge, valid_out rises SYNC_STAGES+2 edges later (+1 edge of sampling uncertainty).
- Simultaneous events:
  - ready_in in the same cycle as a new completion in HOLD: the handshake completes and the new token is evaluated from IDLE on the next cycle. No ovf is raised.
- FP back-to-back: a second code change without an intervening spacer is not a token. If stable in SPACER without ever reaching 00, no new token is produced.

Optional Feature:
- Macro: DUAL_RAIL_RX_ACK_EN.
- When defined, adds output port ack (1 bit, reset 0), driven to upstream:
  - TP: ack toggles on each accepted token (IDLE->HOLD).
  - FP: ack rises on acceptance and falls on leaving SPACER.
- ovf is then tied to 0 in FP, where upstream is throttled by ack.
- When undefined, there is no ack port and behaviour is as above.

Decomposition:
- Package dual_rail_pkg:
  - ENC string constants "TP" and "FP".
  - typedef rail_t = logic [1:0].
  - Localparams RAIL_NUM=2, TRUE_RAIL=1, FALSE_RAIL=0.
  - Functions is_complete_fp, is_spacer_fp and is_complete_tp(s, ref).
- Sub-module dual_rail_sync (parameters WIDTH, SYNC_STAGES): per-rail flop chain plus the s_q and stable generation.

Test Plan:
- TP, WIDTH=2, reset then toggle in[0][1] and in[1][0] (ref 00_00 -> 01_10 on {bit1,bit0}) -> valid_out=1 after SYNC_STAGES+2 edges with data_out=2'b01. ready_in=1 -> valid_out=0 next edge.
- TP, toggle only in[0][0] (one of two bits) -> no valid_out for 20 cycles. Then toggle in[1][1] -> data_out=2'b10.
- FP, drive 10_01, then 00_00, then 01_01 with ready_in=1 -> two tokens 2'b10 then 2'b00. Dropping the spacer before a third code -> no third token.
- FP, drive in[1]=11 stable -> err=1 within SYNC_STAGES+2 edges; no valid_out; err holds until rst.
- TP, ready_in=0, issue two complete tokens -> first token held on data_out, ovf=1, valid_out stays 1. rst mid-HOLD -> valid_out, ovf and ref all 0 on the next edge.
- With DUAL_RAIL_RX_ACK_EN, TP: three tokens -> ack toggles 0->1->0->1, one toggle per acceptance.

Source files
------------

// File: rtl/dual_rail_pkg.sv
// Shared types and per-pair code checks for the dual-rail receiver.
package dual_rail_pkg;

  localparam ENC_TP = "TP";
  localparam ENC_FP = "FP";

  typedef logic [1:0] rail_t;

  localparam int RAIL_NUM   = 2;
  localparam int TRUE_RAIL  = 1;
  localparam int FALSE_RAIL = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_SPACER} state_t;

  // Four-phase: a data pair carries exactly one high rail.
  function automatic logic is_complete_fp(rail_t r);
    return r[TRUE_RAIL] ^ r[FALSE_RAIL];
  endfunction

  function automatic logic is_spacer_fp(rail_t r);
    return r == 2'b00;
  endfunction

  function automatic logic is_illegal_fp(rail_t r);
    return &r;
  endfunction

  // Two-phase: a pair is complete when exactly one rail moved since the last token.
  function automatic logic is_complete_tp(rail_t s, rail_t r);
    return ^(s ^ r);
  endfunction

  function automatic logic is_illegal_tp(rail_t s, rail_t r);
    return &(s ^ r);
  endfunction

endpackage

// File: rtl/dual_rail_rx_sync.sv
// Per-rail synchroniser chain plus one-cycle-delayed copy used for the stability test.
module dual_rail_sync #(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0][1:0]  in,
  output logic [WIDTH-1:0][1:0]  s,
  output logic                   stable
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0][1:0] chain;
  logic [WIDTH-1:0][1:0]                  s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      s_q   <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], in};
      s_q   <= s;
    end
  end

  assign s      = chain[SYNC_STAGES-1];
  assign stable = (s == s_q);

endmodule

// File: rtl/dual_rail_rx.sv
// Dual-rail token receiver: sync, completion detect, decode, valid/ready output.
// Optional upstream handshake output ack is enabled by defining DUAL_RAIL_RX_ACK_EN.
module dual_rail_rx
  import dual_rail_pkg::*;
#(
  parameter     ENC         = "TP",
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0][1:0] in,
  output logic [WIDTH-1:0]      data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  err,
  output logic                  ovf
`ifdef DUAL_RAIL_RX_ACK_EN
  ,
  output logic                  ack
`endif
);

  localparam bit IS_TP = (ENC == ENC_TP);

  logic [WIDTH-1:0][1:0] s;
  logic                  stable;
  logic [WIDTH-1:0][1:0] ref_q;
  logic [WIDTH-1:0]      decoded;
  logic                  complete, spacer, illegal;
  state_t                state_q, state_d;
  logic                  accept, ovf_set;

  dual_rail_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .s      (s),
    .stable (stable)
  );

  always_comb begin
    complete = 1'b1;
    spacer   = 1'b1;
    illegal  = 1'b0;
    decoded  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (IS_TP) begin
        complete   &= is_complete_tp(s[i], ref_q[i]);
        illegal    |= is_illegal_tp(s[i], ref_q[i]);
        decoded[i]  = s[i][TRUE_RAIL] ^ ref_q[i][TRUE_RAIL];
      end else begin
        complete   &= is_complete_fp(s[i]);
        illegal    |= is_illegal_fp(s[i]);
        decoded[i]  = s[i][TRUE_RAIL];
      end
      spacer &= is_spacer_fp(s[i]);
    end
  end

  // A handshake in HOLD wins over a coincident completion; that token is re-evaluated from IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (complete && stable) begin
          state_d = ST_HOLD;
          accept  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (ready_in)
          state_d = IS_TP ? ST_IDLE : ST_SPACER;
        else if (IS_TP && complete && stable)
          ovf_set = 1'b1;
      end
      ST_SPACER: begin
        if (spacer && stable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ref_q     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_out <= (state_d == ST_HOLD);
      if (accept) data_out <= decoded;
      // A dropped token still advances the reference so the next toggle is judged against it.
      if (IS_TP && (accept || ovf_set)) ref_q <= s;
      if (illegal && stable) err <= 1'b1;
      if (ovf_set) ovf <= 1'b1;
    end
  end

`ifdef DUAL_RAIL_RX_ACK_EN
  always_ff @(posedge clk) begin
    if (rst)
      ack <= 1'b0;
    else if (accept)
      ack <= IS_TP ? ~ack : 1'b1;
    else if (!IS_TP && state_q == ST_SPACER && state_d == ST_IDLE)
      ack <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_dual_rail_rx.sv
// Randomised self-checking bench for dual_rail_rx: one TP and one FP instance side by side.
module tb_dual_rail_rx;

  localparam int W  = 2;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0][1:0] in_tp, in_fp;
  logic [W-1:0]      data_tp, data_fp;
  logic              valid_tp, valid_fp, rdy_tp, rdy_fp;
  logic              err_tp, err_fp, ovf_tp, ovf_fp;
  logic              ack_tp, ack_fp;

  int errors = 0;
  int checks = 0;

  // Bench-side rail state: TP rails are toggled by the encoder below.
  logic [W-1:0][1:0] rails_tp;

  always #5 clk = ~clk;

  dual_rail_rx #(.ENC("TP"), .WIDTH(W), .SYNC_STAGES(SS)) dut_tp (
    .clk(clk), .rst(rst), .in(in_tp), .data_out(data_tp), .valid_out(valid_tp),
    .ready_in(rdy_tp), .err(err_tp), .ovf(ovf_tp)
`ifdef DUAL_RAIL_RX_ACK_EN
    , .ack(ack_tp)
`endif
  );

  dual_rail_rx #(.ENC("FP"), .WIDTH(W), .SYNC_STAGES(SS)) dut_fp (
    .clk(clk), .rst(rst), .in(in_fp), .data_out(data_fp), .valid_out(valid_fp),
    .ready_in(rdy_fp), .err(err_fp), .ovf(ovf_fp)
`ifdef DUAL_RAIL_RX_ACK_EN
    , .ack(ack_fp)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two-phase encoder: a 1 toggles the true rail, a 0 toggles the false rail.
  task automatic send_tp(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      if (d[i]) rails_tp[i][1] = ~rails_tp[i][1];
      else      rails_tp[i][0] = ~rails_tp[i][0];
    end
    in_tp = rails_tp;
  endtask

  // Four-phase encoder: 1 -> 10, 0 -> 01.
  task automatic send_fp(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) in_fp[i] = d[i] ? 2'b10 : 2'b01;
  endtask

  task automatic wait_tp(input int max, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      tick();
      if (valid_tp) seen = 1'b1;
    end
  endtask

  task automatic wait_fp(input int max, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      tick();
      if (valid_fp) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_tp = '0; in_fp = '0; rails_tp = '0; rdy_tp = 1'b0; rdy_fp = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({valid_tp, err_tp, ovf_tp, data_tp} !== '0) begin
      errors++; $display("FAIL reset_tp: got %b want 00000", {valid_tp, err_tp, ovf_tp, data_tp});
    end
    checks++;
    if ({valid_fp, err_fp, ovf_fp, data_fp} !== '0) begin
      errors++; $display("FAIL reset_fp: got %b want 00000", {valid_fp, err_fp, ovf_fp, data_fp});
    end
  endtask

  task automatic test_tp_basic();
    rdy_tp = 1'b0;
    send_tp(2'b01);
    for (int k = 0; k < SS + 1; k++) tick();
    checks++;
    if (valid_tp !== 1'b0) begin errors++; $display("FAIL tp_early: valid got %b want 0", valid_tp); end
    tick();
    checks++;
    if (valid_tp !== 1'b1 || data_tp !== 2'b01) begin
      errors++; $display("FAIL tp_latency: valid=%b data=%b want 1/01", valid_tp, data_tp);
    end
    rdy_tp = 1'b1;
    tick();
    rdy_tp = 1'b0;
    checks++;
    if (valid_tp !== 1'b0) begin errors++; $display("FAIL tp_consume: valid got %b want 0", valid_tp); end
  endtask

  task automatic test_tp_partial();
    bit seen;
    rails_tp[0][0] = ~rails_tp[0][0];
    in_tp = rails_tp;
    wait_tp(20, seen);
    checks++;
    if (seen) begin errors++; $display("FAIL tp_partial: valid got 1 want 0"); end
    rails_tp[1][1] = ~rails_tp[1][1];
    in_tp = rails_tp;
    rdy_tp = 1'b1;
    wait_tp(10, seen);
    checks++;
    if (!seen || data_tp !== 2'b10) begin
      errors++; $display("FAIL tp_partial_done: seen=%0d data=%b want 1/10", seen, data_tp);
    end
    tick();
  endtask

  task automatic test_tp_random();
    bit seen;
    logic [W-1:0] d;
    rdy_tp = 1'b1;
    for (int n = 0; n < 8; n++) begin
      d = W'($urandom);
      send_tp(d);
      wait_tp(10, seen);
      checks++;
      if (!seen || data_tp !== d) begin
        errors++; $display("FAIL tp_random[%0d]: seen=%0d data=%b want %b", n, seen, data_tp, d);
      end
      tick();
    end
    rdy_tp = 1'b0;
  endtask

  task automatic test_simultaneous();
    bit seen;
    logic [W-1:0] d1, d2;
    d1 = W'($urandom);
    d2 = W'($urandom);
    send_tp(d1);
    wait_tp(10, seen);
    checks++;
    if (!seen || data_tp !== d1) begin
      errors++; $display("FAIL sim_first: seen=%0d data=%b want %b", seen, data_tp, d1);
    end
    send_tp(d2);
    for (int k = 0; k < SS + 1; k++) tick();
    rdy_tp = 1'b1;
    tick();
    rdy_tp = 1'b0;
    checks++;
    if (valid_tp !== 1'b0 || ovf_tp !== 1'b0) begin
      errors++; $display("FAIL sim_handshake: valid=%b ovf=%b want 0/0", valid_tp, ovf_tp);
    end
    tick();
    checks++;
    if (valid_tp !== 1'b1 || data_tp !== d2) begin
      errors++; $display("FAIL sim_second: valid=%b data=%b want 1/%b", valid_tp, data_tp, d2);
    end
    rdy_tp = 1'b1;
    tick();
    rdy_tp = 1'b0;
  endtask

  task automatic test_tp_ovf();
    bit seen;
    logic [W-1:0] d1, d2, d3;
    d1 = W'($urandom); d2 = W'($urandom); d3 = W'($urandom);
    rdy_tp = 1'b0;
    send_tp(d1);
    wait_tp(10, seen);
    send_tp(d2);
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (!seen || ovf_tp !== 1'b1 || valid_tp !== 1'b1 || data_tp !== d1) begin
      errors++; $display("FAIL tp_ovf: ovf=%b valid=%b data=%b want 1/1/%b", ovf_tp, valid_tp, data_tp, d1);
    end
    rst = 1'b1; in_tp = '0; rails_tp = '0;
    tick();
    rst = 1'b0;
    checks++;
    if (valid_tp !== 1'b0 || ovf_tp !== 1'b0 || data_tp !== '0) begin
      errors++; $display("FAIL tp_rst_hold: valid=%b ovf=%b data=%b want 0/0/00", valid_tp, ovf_tp, data_tp);
    end
    // The next token decodes against an all-zero reference.
    rdy_tp = 1'b1;
    send_tp(d3);
    wait_tp(10, seen);
    checks++;
    if (!seen || data_tp !== d3) begin
      errors++; $display("FAIL tp_ref_clear: seen=%0d data=%b want %b", seen, data_tp, d3);
    end
    tick();
    rdy_tp = 1'b0;
  endtask

  task automatic test_tp_err();
    bit seen;
    checks++;
    if (err_tp !== 1'b0) begin errors++; $display("FAIL tp_err_pre: err got %b want 0", err_tp); end
    rails_tp[0] = ~rails_tp[0];
    rails_tp[1][1] = ~rails_tp[1][1];
    in_tp = rails_tp;
    wait_tp(8, seen);
    checks++;
    if (seen || err_tp !== 1'b1) begin
      errors++; $display("FAIL tp_err: valid_seen=%0d err=%b want 0/1", seen, err_tp);
    end
  endtask

  task automatic test_fp_tokens();
    bit seen;
    logic [W-1:0] d;
    rdy_fp = 1'b1;
    in_fp = {2'b10, 2'b01};
    wait_fp(10, seen);
    checks++;
    if (!seen || data_fp !== 2'b10) begin
      errors++; $display("FAIL fp_tok1: seen=%0d data=%b want 10", seen, data_fp);
    end
    in_fp = '0;
    for (int k = 0; k < 6; k++) tick();
    in_fp = {2'b01, 2'b01};
    wait_fp(10, seen);
    checks++;
    if (!seen || data_fp !== 2'b00) begin
      errors++; $display("FAIL fp_tok2: seen=%0d data=%b want 00", seen, data_fp);
    end
    in_fp = {2'b10, 2'b10};
    wait_fp(20, seen);
    checks++;
    if (seen) begin errors++; $display("FAIL fp_no_spacer: valid got 1 want 0"); end
    in_fp = '0;
    for (int k = 0; k < 6; k++) tick();
    for (int n = 0; n < 6; n++) begin
      d = W'($urandom);
      send_fp(d);
      wait_fp(10, seen);
      checks++;
      if (!seen || data_fp !== d) begin
        errors++; $display("FAIL fp_random[%0d]: seen=%0d data=%b want %b", n, seen, data_fp, d);
      end
      in_fp = '0;
      for (int k = 0; k < 6; k++) tick();
    end
    checks++;
    if (ovf_fp !== 1'b0 || err_fp !== 1'b0) begin
      errors++; $display("FAIL fp_flags: ovf=%b err=%b want 0/0", ovf_fp, err_fp);
    end
  endtask

  task automatic test_fp_err();
    bit seen;
    in_fp = {2'b11, 2'b01};
    wait_fp(SS + 3, seen);
    checks++;
    if (seen || err_fp !== 1'b1) begin
      errors++; $display("FAIL fp_err: valid_seen=%0d err=%b want 0/1", seen, err_fp);
    end
    for (int k = 0; k < 10; k++) tick();
    in_fp = '0;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (err_fp !== 1'b1) begin errors++; $display("FAIL fp_err_sticky: err got %b want 1", err_fp); end
    do_reset();
    checks++;
    if (err_fp !== 1'b0 || err_tp !== 1'b0) begin
      errors++; $display("FAIL err_rst: fp=%b tp=%b want 0/0", err_fp, err_tp);
    end
  endtask

`ifdef DUAL_RAIL_RX_ACK_EN
  task automatic test_ack();
    bit seen;
    logic exp_ack;
    exp_ack = 1'b0;
    checks++;
    if (ack_tp !== exp_ack) begin errors++; $display("FAIL ack_rst: got %b want %b", ack_tp, exp_ack); end
    rdy_tp = 1'b1;
    for (int n = 0; n < 3; n++) begin
      send_tp(W'($urandom));
      wait_tp(10, seen);
      exp_ack = ~exp_ack;
      checks++;
      if (!seen || ack_tp !== exp_ack) begin
        errors++; $display("FAIL ack_tp[%0d]: seen=%0d ack=%b want %b", n, seen, ack_tp, exp_ack);
      end
      tick();
    end
    rdy_fp = 1'b1;
    send_fp(W'($urandom));
    wait_fp(10, seen);
    checks++;
    if (!seen || ack_fp !== 1'b1) begin
      errors++; $display("FAIL ack_fp_rise: seen=%0d ack=%b want 1", seen, ack_fp);
    end
    in_fp = '0;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (ack_fp !== 1'b0) begin errors++; $display("FAIL ack_fp_fall: got %b want 0", ack_fp); end
  endtask
`endif

  initial begin
    rst = 1'b1; in_tp = '0; in_fp = '0; rails_tp = '0; rdy_tp = 1'b0; rdy_fp = 1'b0;
    test_reset();
    test_tp_basic();
    test_tp_partial();
    test_tp_random();
    test_simultaneous();
    test_tp_ovf();
    test_tp_err();
    test_fp_tokens();
    test_fp_err();
`ifdef DUAL_RAIL_RX_ACK_EN
    test_ack();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
